trackball_emulator: RTL and testbench

Generates Atari-style trackball quadrature signals (per-axis direction level plus clock pulse train) from signed motion deltas supplied over a valid/ready handshake. It is the transmitter end of the trackball lines consumed by the input network (hordir1/horclk1/verdir1/verclk1). It sits between a host-side motion source (PS/2 mouse decoder, buttons, or bench) and the player-1 trackball inputs, replacing a physical trackball on the JA header.

---
 rtl/trackball_emulator.sv | 203 ++++++++++++++++++++
 tb/tb_trackball_emulator.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trackball_emulator.sv
// Atari-style trackball transmitter: signed dx/dy deltas become per-axis dir level + clock pulse trains.
// Latency: delta accepted on edge N -> dir valid N+1, clock rises N+1+SETUP, pulse period 1+SETUP+2*CLK_DIV.
// Backpressure: registered delta_ready drops while either next pending count would exceed +/-LIMIT.

module trackball_axis #(
  parameter int CLK_DIV = 2000,
  parameter int SETUP   = 4,
  parameter int ACC_W   = 10
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    enable,
  input  logic                    flush,
  input  logic signed [ACC_W-1:0] delta,
  output logic signed [ACC_W-1:0] pend_next,
  output logic                    active,
  output logic                    dir,
  output logic                    pclk
);

  localparam int CNT_MAX = (CLK_DIV > SETUP) ? CLK_DIV : SETUP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP - 1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic signed [ACC_W-1:0] ONE = ACC_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] pend;
  logic signed [ACC_W-1:0] sum;
  logic                    step;

  // One step is emitted on the edge that moves SETUP into HIGH.
  assign step   = (state == S_SETUP) && (cnt == SETUP_LAST);
  assign active = (state != S_IDLE) || (pend != '0);

  // Next pending count: accepted delta and emitted step combine; flush overrides both.
  always_comb begin
    sum       = pend + delta;
    pend_next = sum;
    if (step) begin
      pend_next = dir ? (sum - ONE) : (sum + ONE);
    end
    if (flush) begin
      pend_next = '0;
    end
  end

  // Pending-count accumulator.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pend <= '0;
    end else begin
      pend <= pend_next;
    end
  end

  // Pulse FSM: direction is only latched in IDLE, so an in-flight pulse keeps its sense.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state <= S_IDLE;
      cnt   <= '0;
      dir   <= 1'b0;
      pclk  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt  <= '0;
          pclk <= 1'b0;
          // A flush on this edge empties pend, so starting a pulse would emit a bogus step.
          if (enable && !flush && (pend != '0)) begin
            dir   <= ~pend[ACC_W-1];
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt   <= '0;
            pclk  <= 1'b1;
            state <= S_HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HIGH: begin
          if (cnt == DIV_LAST) begin
            cnt   <= '0;
            pclk  <= 1'b0;
            state <= S_LOW;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_LOW: begin
          if (cnt == DIV_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          pclk  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

module trackball_emulator #(
  parameter int CLK_DIV = 2000,
  parameter int SETUP   = 4,
  parameter int ACC_W   = 10
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic signed [7:0] dx,
  input  logic signed [7:0] dy,
  input  logic              delta_valid,
  output logic              delta_ready,
  input  logic              enable,
  input  logic              flush,
  output logic              hordir,
  output logic              horclk,
  output logic              verdir,
  output logic              verclk,
  output logic              busy
);

  // Headroom of one full 8-bit delta keeps the accumulators from ever overflowing.
  localparam logic signed [ACC_W-1:0] LIMIT  = ACC_W'((1 << (ACC_W - 1)) - 129);
  localparam logic signed [ACC_W-1:0] NLIMIT = -LIMIT;

  logic                    accept;
  logic signed [ACC_W-1:0] add_x;
  logic signed [ACC_W-1:0] add_y;
  logic signed [ACC_W-1:0] pend_next_x;
  logic signed [ACC_W-1:0] pend_next_y;
  logic                    active_x;
  logic                    active_y;
  logic                    room_x;
  logic                    room_y;

  assign accept = delta_valid & delta_ready;
  assign add_x  = accept ? {{(ACC_W - 8){dx[7]}}, dx} : '0;
  assign add_y  = accept ? {{(ACC_W - 8){dy[7]}}, dy} : '0;
  assign room_x = (pend_next_x <= LIMIT) && (pend_next_x >= NLIMIT);
  assign room_y = (pend_next_y <= LIMIT) && (pend_next_y >= NLIMIT);

  trackball_axis #(
    .CLK_DIV (CLK_DIV),
    .SETUP   (SETUP),
    .ACC_W   (ACC_W)
  ) u_hor (
    .clk       (clk),
    .rst_l     (rst_l),
    .enable    (enable),
    .flush     (flush),
    .delta     (add_x),
    .pend_next (pend_next_x),
    .active    (active_x),
    .dir       (hordir),
    .pclk      (horclk)
  );

  trackball_axis #(
    .CLK_DIV (CLK_DIV),
    .SETUP   (SETUP),
    .ACC_W   (ACC_W)
  ) u_ver (
    .clk       (clk),
    .rst_l     (rst_l),
    .enable    (enable),
    .flush     (flush),
    .delta     (add_y),
    .pend_next (pend_next_y),
    .active    (active_y),
    .dir       (verdir),
    .pclk      (verclk)
  );

  // Registered ready and busy, both derived from the state being loaded on this edge.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      delta_ready <= 1'b0;
      busy        <= 1'b0;
    end else begin
      delta_ready <= room_x && room_y;
      busy        <= active_x || active_y;
    end
  end

endmodule

// File: tb/tb_trackball_emulator.sv
// Bench for trackball_emulator: expected pulses are queued per axis when deltas are driven,
// and a negedge monitor pops and checks direction, rise cycle and high width of every pulse.
// Direct checks cover reset values, ready/backpressure, flush and busy timing.

module tb_trackball_emulator;

  localparam int CLK_DIV = 4;
  localparam int SETUP   = 2;
  localparam int ACC_W   = 10;
  localparam int PERIOD  = 1 + SETUP + 2 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic [7:0] dx = 8'd0;
  logic [7:0] dy = 8'd0;
  logic       delta_valid = 1'b0;
  logic       enable = 1'b1;
  logic       flush = 1'b0;
  logic       delta_ready;
  logic       hordir;
  logic       horclk;
  logic       verdir;
  logic       verclk;
  logic       busy;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic dir;
    int   rise;
  } pulse_t;

  pulse_t q[2][$];
  logic   in_p[2];
  int     rise_c[2];
  logic   rise_d[2];
  logic   mc;
  logic   md;
  pulse_t cur;

  trackball_emulator #(
    .CLK_DIV (CLK_DIV),
    .SETUP   (SETUP),
    .ACC_W   (ACC_W)
  ) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .dx          (dx),
    .dy          (dy),
    .delta_valid (delta_valid),
    .delta_ready (delta_ready),
    .enable      (enable),
    .flush       (flush),
    .hordir      (hordir),
    .horclk      (horclk),
    .verdir      (verdir),
    .verclk      (verclk),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int a, input logic d, input int rise);
    pulse_t p;
    p.dir  = d;
    p.rise = rise;
    q[a].push_back(p);
  endtask

  // Pulse monitor for both axes, sampled on the falling edge.
  always @(negedge clk) begin
    for (int a = 0; a < 2; a++) begin
      mc = (a == 0) ? horclk : verclk;
      md = (a == 0) ? hordir : verdir;
      if (!rst_l) begin
        in_p[a] = 1'b0;
      end else if (mc && !in_p[a]) begin
        in_p[a]   = 1'b1;
        rise_c[a] = cyc;
        rise_d[a] = md;
        chk((a == 0) ? "hor pulse expected" : "ver pulse expected", 32'(q[a].size() != 0), 1);
        if (q[a].size() != 0) begin
          cur = q[a].pop_front();
          chk((a == 0) ? "hor pulse dir" : "ver pulse dir", 32'(md), 32'(cur.dir));
          if (cur.rise >= 0) begin
            chk((a == 0) ? "hor rise cycle" : "ver rise cycle", cyc, cur.rise);
          end
        end
      end else if (!mc && in_p[a]) begin
        in_p[a] = 1'b0;
        chk((a == 0) ? "hor high width" : "ver high width", cyc - rise_c[a], CLK_DIV);
        chk((a == 0) ? "hor dir stable" : "ver dir stable", 32'(md), 32'(rise_d[a]));
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Present a delta at a negedge; returns the accept edge and cycles spent waiting for ready.
  task automatic send(input logic [7:0] x, input logic [7:0] y, output int acc, output int waited);
    int n = 0;
    dx = x;
    dy = y;
    delta_valid = 1'b1;
    while (!delta_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("send ready seen", 32'(delta_ready), 1);
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    waited = n;
    delta_valid = 1'b0;
    dx = 8'd0;
    dy = 8'd0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    repeat (2) @(negedge clk);
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("idle reached", 32'(busy), 0);
    chk("hor pulses all seen", q[0].size(), 0);
    chk("ver pulses all seen", q[1].size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int acc2;
    int w;
    int k;

    // Reset values.
    @(negedge clk);
    chk("outs in reset", {delta_ready, hordir, horclk, verdir, verclk, busy}, 0);
    repeat (3) @(negedge clk);
    chk("outs in reset late", {delta_ready, hordir, horclk, verdir, verclk, busy}, 0);
    rst_l = 1'b1;
    @(negedge clk);
    chk("ready after reset", 32'(delta_ready), 1);
    chk("busy after reset", 32'(busy), 0);
    repeat (3) @(negedge clk);

    // dx = +3: three positive pulses, one period apart.
    send(8'd3, 8'd0, acc, w);
    for (int i = 0; i < 3; i++) push(0, 1'b1, acc + 3 + PERIOD * i);
    @(negedge clk);
    chk("hordir after +3", 32'(hordir), 1);
    wait_until(acc + 33);
    chk("busy still high", 32'(busy), 1);
    wait_until(acc + 36);
    chk("busy dropped", 32'(busy), 0);
    chk("hor +3 pulses seen", q[0].size(), 0);

    // dy = -2: two negative vertical pulses.
    send(8'd0, 8'hFE, acc, w);
    push(1, 1'b0, acc + 3);
    push(1, 1'b0, acc + 3 + PERIOD);
    @(negedge clk);
    chk("verdir after -2", 32'(verdir), 0);
    wait_idle(200);

    // Both axes at once, opposite senses.
    send(8'hFF, 8'h01, acc, w);
    push(0, 1'b0, acc + 3);
    push(1, 1'b1, acc + 3);
    @(negedge clk);
    chk("dirs for -1/+1", {hordir, verdir}, 2'b01);
    wait_idle(200);

    // Reversal during a pulse: +2 then -5 landing in the first HIGH.
    send(8'd2, 8'd0, acc, w);
    push(0, 1'b1, acc + 3);
    for (int i = 1; i <= 4; i++) push(0, 1'b0, acc + 3 + PERIOD * i);
    wait_until(acc + 3);
    chk("in HIGH before -5", 32'(horclk), 1);
    send(8'hFB, 8'd0, acc2, w);
    chk("-5 accept edge", acc2, acc + 4);
    wait_idle(300);

    // Streaming +127 with enable low fills to 508 then backpressures.
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(8'd127, 8'd0, acc, w);
      chk("stream accept wait", w, 0);
    end
    chk("ready low at 508", 32'(delta_ready), 0);
    chk("busy with pend only", 32'(busy), 1);
    repeat (20) @(negedge clk);
    chk("ready still low", 32'(delta_ready), 0);
    enable = 1'b1;
    k = cyc;
    for (int i = 0; i < 508; i++) push(0, 1'b1, k + 3 + PERIOD * i);
    wait_until(k + 3 + PERIOD * 124 - 1);
    chk("ready before 383", 32'(delta_ready), 0);
    @(negedge clk);
    chk("ready at 383", 32'(delta_ready), 1);
    wait_idle(6000);

    // Flush in HIGH with pend 7 and a simultaneous +5 accept.
    send(8'd8, 8'd0, acc, w);
    push(0, 1'b1, acc + 3);
    wait_until(acc + 3);
    chk("in HIGH before flush", 32'(horclk), 1);
    flush = 1'b1;
    dx = 8'd5;
    delta_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    delta_valid = 1'b0;
    dx = 8'd0;
    chk("ready after flush", 32'(delta_ready), 1);
    chk("pulse completes", 32'(horclk), 1);
    wait_idle(200);
    repeat (30) @(negedge clk);
    chk("no pulses after flush", 32'(busy), 0);

    // Reset for 3 cycles in the middle of HIGH.
    send(8'd3, 8'd0, acc, w);
    push(0, 1'b1, acc + 3);
    wait_until(acc + 4);
    #2 rst_l = 1'b0;
    #1 chk("horclk drops on reset", 32'(horclk), 0);
    repeat (3) begin
      @(negedge clk);
      chk("outs in mid reset", {delta_ready, hordir, horclk, verdir, verclk, busy}, 0);
    end
    #2 rst_l = 1'b1;
    repeat (40) @(negedge clk);
    chk("idle after reset", 32'(busy), 0);
    chk("ready after reset 2", 32'(delta_ready), 1);
    chk("queue after reset", q[0].size(), 0);
    send(8'd1, 8'd0, acc, w);
    push(0, 1'b1, acc + 3);
    wait_idle(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
